// File: rtl/countdown_timer_if.sv
// Control/status bundle between a CPU-side driver and countdown_timer.
interface countdown_timer_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  en;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_val;
    logic                  start;
    logic                  stop;
    logic                  auto_reload;
    logic                  irq_ack;
    logic [DATA_WIDTH-1:0] count;
    logic                  busy;
    logic                  done;
    logic                  tc;
    logic                  irq;

    modport master (
        output en, load, load_val, start, stop, auto_reload, irq_ack,
        input  count, busy, done, tc, irq
    );

    modport slave (
        input  en, load, load_val, start, stop, auto_reload, irq_ack,
        output count, busy, done, tc, irq
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter timer with terminal-count pulse, sticky irq and optional auto-reload.
// Optional prescaler on decrement events enabled by `define TIMER_PRESCALER_EN.
module countdown_timer #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned PRESCALE_DIV = 4
) (
    input logic             clk,
    input logic             rst_n,
    countdown_timer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    if (PRESCALE_DIV == 0) begin : g_bad_div
        $error("PRESCALE_DIV must be >= 1");
    end

    state_t                state_q, state_nxt;
    logic [DATA_WIDTH-1:0] count_q, count_nxt;
    logic [DATA_WIDTH-1:0] reload_q, reload_nxt;
    logic                  tc_q, tc_nxt;
    logic                  irq_q, irq_nxt;
    logic                  dec_event;

`ifdef TIMER_PRESCALER_EN
    localparam int unsigned PSC_W = $clog2(PRESCALE_DIV) + 1;
    logic [PSC_W-1:0] psc_q, psc_nxt;
    logic             psc_wrap;

    assign psc_wrap  = (psc_q == PSC_W'(PRESCALE_DIV - 1));
    assign dec_event = bus.en && psc_wrap;
`else
    assign dec_event = bus.en;
`endif

    // State and datapath registers; reset is active-high despite the name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            irq_q    <= 1'b0;
`ifdef TIMER_PRESCALER_EN
            psc_q    <= '0;
`endif
        end else begin
            state_q  <= state_nxt;
            count_q  <= count_nxt;
            reload_q <= reload_nxt;
            tc_q     <= tc_nxt;
            irq_q    <= irq_nxt;
`ifdef TIMER_PRESCALER_EN
            psc_q    <= psc_nxt;
`endif
        end
    end

    // Next-state: load beats stop beats start; stop also wins over a decrement.
    always_comb begin
        state_nxt  = state_q;
        count_nxt  = count_q;
        reload_nxt = reload_q;
        tc_nxt     = 1'b0;
        irq_nxt    = irq_q & ~bus.irq_ack;
`ifdef TIMER_PRESCALER_EN
        psc_nxt    = psc_q;
`endif

        if (bus.load) begin
            count_nxt  = bus.load_val;
            reload_nxt = bus.load_val;
            state_nxt  = IDLE;
`ifdef TIMER_PRESCALER_EN
            psc_nxt    = '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.stop && bus.start && count_q != '0) begin
                        state_nxt = RUN;
`ifdef TIMER_PRESCALER_EN
                        psc_nxt   = '0;
`endif
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_nxt = IDLE;
                    end else begin
`ifdef TIMER_PRESCALER_EN
                        if (bus.en) psc_nxt = psc_wrap ? '0 : psc_q + PSC_W'(1);
`endif
                        if (dec_event) begin
                            if (count_q > DATA_WIDTH'(1)) begin
                                count_nxt = count_q - DATA_WIDTH'(1);
                            end else if (count_q == DATA_WIDTH'(1)) begin
                                tc_nxt  = 1'b1;
                                irq_nxt = 1'b1;
                                if (bus.auto_reload && reload_q != '0) begin
                                    count_nxt = reload_q;
                                end else begin
                                    count_nxt = '0;
                                    state_nxt = DONE;
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    if (!bus.stop && bus.start && reload_q != '0) begin
                        count_nxt = reload_q;
                        state_nxt = RUN;
`ifdef TIMER_PRESCALER_EN
                        psc_nxt   = '0;
`endif
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.tc    = tc_q;
    assign bus.irq   = irq_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
module tb_countdown_timer;
    localparam int unsigned DW  = 16;
    localparam int unsigned DIV = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    countdown_timer_if #(.DATA_WIDTH(DW)) bus ();

    countdown_timer #(.DATA_WIDTH(DW), .PRESCALE_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [31:0] cnt, input logic busy, input logic done,
                          input logic tc, input logic irq);
        chk({tag, ".count"}, 32'(bus.count), cnt);
        chk({tag, ".busy"},  32'(bus.busy),  32'(busy));
        chk({tag, ".done"},  32'(bus.done),  32'(done));
        chk({tag, ".tc"},    32'(bus.tc),    32'(tc));
        chk({tag, ".irq"},   32'(bus.irq),   32'(irq));
    endtask

    task automatic do_load(input logic [DW-1:0] v);
        bus.load_val = v;
        bus.load     = 1'b1;
        step();
        bus.load     = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        bus.en = 1'b0; bus.load = 1'b0; bus.load_val = '0; bus.start = 1'b0;
        bus.stop = 1'b0; bus.auto_reload = 1'b0; bus.irq_ack = 1'b0;
        repeat (2) step();
        chk_st("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b0;

        // 1: async reset while running at 7
        do_load(16'd7);
        chk_st("t1.load", 7, 0, 0, 0, 0);
        do_start();
        chk_st("t1.run", 7, 1, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        chk_st("t1.async", 0, 0, 0, 0, 0);
        step();
        chk_st("t1.held", 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        step();
        chk_st("t1.release", 0, 0, 0, 0, 0);

        // 2: one-shot run of 3, then restart from DONE
        do_load(16'd3);
        do_start();
        chk_st("t2.start", 3, 1, 0, 0, 0);
        bus.en = 1'b1;
        step(); chk_st("t2.c2", 2, 1, 0, 0, 0);
        step(); chk_st("t2.c1", 1, 1, 0, 0, 0);
        step(); chk_st("t2.tc", 0, 0, 1, 1, 1);
        step(); chk_st("t2.done", 0, 0, 1, 0, 1);
        do_start();
        chk_st("t2.restart", 3, 1, 0, 0, 1);
        step(); chk_st("t2.r2", 2, 1, 0, 0, 1);
        step(); chk_st("t2.r1", 1, 1, 0, 0, 1);
        step(); chk_st("t2.rtc", 0, 0, 1, 1, 1);
        bus.en = 1'b0;
        bus.irq_ack = 1'b1;
        step(); chk_st("t2.ack", 0, 0, 1, 0, 0);
        bus.irq_ack = 1'b0;

        // 3: auto-reload of 2, ack collisions
        bus.auto_reload = 1'b1;
        do_load(16'd2);
        chk_st("t3.load", 2, 0, 0, 0, 0);
        do_start();
        bus.en = 1'b1;
        step(); chk_st("t3.c1", 1, 1, 0, 0, 0);
        step(); chk_st("t3.tc1", 2, 1, 0, 1, 1);
        step(); chk_st("t3.c1b", 1, 1, 0, 0, 1);
        bus.irq_ack = 1'b1;
        step(); chk_st("t3.ack_on_tc", 2, 1, 0, 1, 1);
        step(); chk_st("t3.ack_off_tc", 1, 1, 0, 0, 0);
        bus.irq_ack = 1'b0;
        step(); chk_st("t3.tc3", 2, 1, 0, 1, 1);
        bus.en = 1'b0;
        bus.auto_reload = 1'b0;
        bus.irq_ack = 1'b1;
        step(); chk_st("t3.ack", 2, 1, 0, 0, 0);
        bus.irq_ack = 1'b0;

        // 4: stop / resume, stop wins over start
        do_load(16'd10);
        chk_st("t4.load", 10, 0, 0, 0, 0);
        do_start();
        bus.en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("t4.down", 32'(bus.count), 32'(10 - i));
        end
        bus.stop = 1'b1;
        step(); chk_st("t4.stop", 5, 0, 0, 0, 0);
        bus.stop = 1'b0;
        step(); chk_st("t4.hold", 5, 0, 0, 0, 0);
        bus.start = 1'b1; bus.stop = 1'b1;
        step(); chk_st("t4.both", 5, 0, 0, 0, 0);
        bus.stop = 1'b0;
        step(); chk_st("t4.resume", 5, 1, 0, 0, 0);
        bus.start = 1'b0;
        step(); chk("t4.c4", 32'(bus.count), 32'd4);
        step(); chk("t4.c3", 32'(bus.count), 32'd3);

        // 5: zero load ignored, en gating
        bus.en = 1'b0;
        do_load(16'd0);
        chk_st("t5.load0", 0, 0, 0, 0, 0);
        do_start();
        chk_st("t5.start0", 0, 0, 0, 0, 0);
        do_load(16'd4);
        do_start();
        chk_st("t5.start4", 4, 1, 0, 0, 0);
        bus.en = 1'b1; step(); chk("t5.e1", 32'(bus.count), 32'd3);
        bus.en = 1'b0; step(); chk("t5.e0", 32'(bus.count), 32'd3);
        bus.en = 1'b1; step(); chk("t5.e1b", 32'(bus.count), 32'd2);
        bus.en = 1'b0; step(); chk("t5.e0b", 32'(bus.count), 32'd2);

`ifdef TIMER_PRESCALER_EN
        // 6: prescaled decrements
        do_load(16'd2);
        bus.en = 1'b1;
        do_start();
        chk_st("t6.start", 2, 1, 0, 0, 0);
        for (int k = 1; k <= 2 * DIV; k++) begin
            step();
            chk("t6.count", 32'(bus.count), (k < DIV) ? 32'd2 : (k < 2 * DIV) ? 32'd1 : 32'd0);
            chk("t6.tc", 32'(bus.tc), (k == 2 * DIV) ? 32'd1 : 32'd0);
        end
        bus.en = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
